// File: rtl/niosmp_async_tx.sv
`default_nettype none
// ============================================================================
// Module  : niosmp_async_tx
// Brief   : Async serial transmitter with a one-byte holding register,
//           start/8N/optional parity/1-2 stop framing, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module niosmp_async_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] tx_data,
  input  logic       load,
  output logic       sent,
  output logic       txd,
  output logic       tx_busy,
  output logic       overrun
);

  localparam logic [2:0]  c_idle      = 3'd0;
  localparam logic [2:0]  c_start     = 3'd1;
  localparam logic [2:0]  c_data      = 3'd2;
  localparam logic [2:0]  c_parity    = 3'd3;
  localparam logic [2:0]  c_stop      = 3'd4;
  localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  c_stop_last = 3'(STOP_BITS - 1);

  logic [2:0]  r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic        r_load_d;
  logic        r_txd;
  logic        r_overrun;

  logic w_load_edge;
  logic w_baud_end;
  logic w_take;
  logic w_hold_par;

  assign w_load_edge = load & ~r_load_d;
  assign w_baud_end  = (r_baud == c_baud_last);
  assign w_hold_par  = (PARITY == 2) ? ~(^r_hold) : (^r_hold);
  // Shifter takes the held byte when idle, or at the very last stop-bit cycle
  assign w_take = r_hold_full &
                  ((r_state == c_idle) |
                   ((r_state == c_stop) & w_baud_end & (r_bit_cnt == c_stop_last)));

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_load_d    <= 1'b0;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_load_d  <= load;
      r_overrun <= 1'b0;
      if (w_load_edge && (!r_hold_full || w_take)) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else begin
        if (w_load_edge) r_overrun <= 1'b1;
        if (w_take) r_hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= c_idle;
      r_baud    <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        c_idle: begin
          r_txd  <= 1'b1;
          r_baud <= 16'd0;
          if (w_take) begin
            r_shift   <= r_hold;
            r_par_bit <= w_hold_par;
            r_bit_cnt <= 3'd0;
            r_state   <= c_start;
            r_txd     <= 1'b0;
          end
        end
        c_start: begin
          if (w_baud_end) begin
            r_baud  <= 16'd0;
            r_state <= c_data;
            r_txd   <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        c_data: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              if (PARITY != 0) begin
                r_state <= c_parity;
                r_txd   <= r_par_bit;
              end else begin
                r_state <= c_stop;
                r_txd   <= 1'b1;
              end
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        c_parity: begin
          if (w_baud_end) begin
            r_baud  <= 16'd0;
            r_state <= c_stop;
            r_txd   <= 1'b1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        c_stop: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            if (r_bit_cnt == c_stop_last) begin
              r_bit_cnt <= 3'd0;
              // Back-to-back: reload straight into START with no idle gap
              if (w_take) begin
                r_shift   <= r_hold;
                r_par_bit <= w_hold_par;
                r_state   <= c_start;
                r_txd     <= 1'b0;
              end else begin
                r_state <= c_idle;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= c_idle;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign sent    = ~r_hold_full;
  assign txd     = r_txd;
  assign tx_busy = (r_state != c_idle);
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_niosmp_async_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_niosmp_async_tx
// Brief   : Three transmitter variants driven from one stimulus stream and
//           compared against a timestamp-based frame model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_niosmp_async_tx;

  localparam int NI = 3;

  logic          clk_clk     = 1'b0;
  logic          reset_reset = 1'b1;
  logic [7:0]    tx_data     = 8'h00;
  logic          load        = 1'b0;
  logic [NI-1:0] sent, txd, tx_busy, overrun;

  int bd  [NI] = '{4, 4, 5};
  int par [NI] = '{0, 1, 2};
  int stp [NI] = '{1, 2, 1};

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  niosmp_async_tx #(.BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .tx_data(tx_data), .load(load),
    .sent(sent[0]), .txd(txd[0]), .tx_busy(tx_busy[0]), .overrun(overrun[0]));
  niosmp_async_tx #(.BAUD_DIV(4), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .tx_data(tx_data), .load(load),
    .sent(sent[1]), .txd(txd[1]), .tx_busy(tx_busy[1]), .overrun(overrun[1]));
  niosmp_async_tx #(.BAUD_DIV(5), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .tx_data(tx_data), .load(load),
    .sent(sent[2]), .txd(txd[2]), .tx_busy(tx_busy[2]), .overrun(overrun[2]));

  always #5 clk_clk = ~clk_clk;

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Line image of one character: start, data LSB first, parity, then idle-high stops
  function automatic logic [11:0] frame_bits(input int p, input logic [7:0] b);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
    if (p == 1) f[9] = ^b;
    else if (p == 2) f[9] = ~(^b);
    return f;
  endfunction

  // Model: a frame taken at edge t occupies the line for samples t..t+len-1
  bit          m_hv    [NI];
  logic [7:0]  m_hb    [NI];
  int          m_start [NI];
  int          m_until [NI];
  logic [11:0] m_fbits [NI];
  bit          m_ovr   [NI];
  bit          m_load_prev = 1'b0;

  always @(posedge clk_clk) begin : model
    bit le, take;
    int len;
    logic exp_txd, exp_busy;
    cyc++;
    le = load & ~m_load_prev;
    for (int i = 0; i < NI; i++) begin
      if (reset_reset) begin
        m_hv[i]    = 1'b0;
        m_until[i] = 0;
        m_start[i] = 0;
        m_ovr[i]   = 1'b0;
      end else begin
        take = m_hv[i] && (cyc >= m_until[i]);
        if (take) begin
          len        = (10 + ((par[i] != 0) ? 1 : 0) + stp[i] - 1) * bd[i];
          m_start[i] = cyc;
          m_until[i] = cyc + len;
          m_fbits[i] = frame_bits(par[i], m_hb[i]);
        end
        m_ovr[i] = le && m_hv[i] && !take;
        if (le && (!m_hv[i] || take)) begin
          m_hb[i] = tx_data;
          m_hv[i] = 1'b1;
        end else if (take) begin
          m_hv[i] = 1'b0;
        end
      end
    end
    m_load_prev = reset_reset ? 1'b0 : load;
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_busy = (cyc >= m_start[i]) && (cyc < m_until[i]);
      exp_txd  = exp_busy ? m_fbits[i][(cyc - m_start[i]) / bd[i]] : 1'b1;
      check_val($sformatf("txd_u%0d", i), txd[i], exp_txd);
      check_val($sformatf("tx_busy_u%0d", i), tx_busy[i], exp_busy);
      check_val($sformatf("sent_u%0d", i), sent[i], ~m_hv[i]);
      check_val($sformatf("overrun_u%0d", i), overrun[i], m_ovr[i]);
    end
  end

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk_clk);
    tx_data = b;
    load    = 1'b1;
    repeat (hold) @(negedge clk_clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Reset must take effect between clock edges, not at the next one
  task automatic pulse_reset(input int n);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("async_txd_u%0d", i), txd[i], 1'b1);
      check_val($sformatf("async_sent_u%0d", i), sent[i], 1'b1);
      check_val($sformatf("async_busy_u%0d", i), tx_busy[i], 1'b0);
      check_val($sformatf("async_ovr_u%0d", i), overrun[i], 1'b0);
    end
    repeat (n) @(negedge clk_clk);
    reset_reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    idle(2);
    send(8'h55, 1); idle(60);
    send(8'h07, 1); idle(60);
    send(8'hA3, 1); idle(15); send(8'h3C, 1); idle(120);
    send(8'h11, 1); idle(2); send(8'h22, 1); idle(2); send(8'h33, 1); idle(150);
    send(8'h5A, 1); idle(17); pulse_reset(2);
    send(8'hF0, 1); idle(80);
    send(8'h81, 100); idle(80);
    repeat (250) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
      else send(8'($urandom), $urandom_range(1, 5));
      idle($urandom_range(0, 50));
    end
    idle(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
